// File: rtl/controla_fase.sv
// controla_fase: traffic-light phase sequencer; loads a 2-digit BCD duration and counts it down on ticks.
// Optional build macro CONTROLA_FASE_PAUSA_EN adds a pausa input that freezes counting in CONTA.
module controla_fase #(
   parameter logic [1:0] ULTIMO_ESTADO = 2'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       caso_esp,
`ifdef CONTROLA_FASE_PAUSA_EN
   input  logic       pausa,
`endif
   input  logic [3:0] unid_preset,
   input  logic [1:0] dez_preset,
   output logic [1:0] estado,
   output logic       caso_esp_lat,
   output logic [3:0] unid,
   output logic [1:0] dez,
   output logic       carga,
   output logic       fim
);

   typedef enum logic {CARGA, CONTA} fsm_t;

   fsm_t       fsm;
   logic       conta_en;
   logic       preset_zero;
   logic       expira;
   logic [1:0] prox_estado;

   // Units presets above 9 are not valid BCD; they saturate to 9.
   function automatic logic [3:0] satura_bcd(input logic [3:0] v);
      return (v > 4'd9) ? 4'd9 : v;
   endfunction

`ifdef CONTROLA_FASE_PAUSA_EN
   assign conta_en = tick & ~pausa;
`else
   assign conta_en = tick;
`endif

   assign preset_zero = (dez_preset == 2'd0) && (unid_preset == 4'd0);
   assign expira      = (dez == 2'd0) && (unid == 4'd1);
   assign prox_estado = (estado == ULTIMO_ESTADO) ? 2'd0 : estado + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm          <= CARGA;
         estado       <= 2'd0;
         caso_esp_lat <= 1'b0;
         unid         <= 4'd0;
         dez          <= 2'd0;
         carga        <= 1'b0;
         fim          <= 1'b0;
      end else begin
         carga <= 1'b0;
         fim   <= 1'b0;
         case (fsm)
            CARGA: begin
               // A zero-length phase advances straight away and stays in CARGA for the next preset.
               if (preset_zero) begin
                  estado       <= prox_estado;
                  caso_esp_lat <= caso_esp;
                  fim          <= 1'b1;
                  carga        <= 1'b1;
               end else begin
                  unid <= satura_bcd(unid_preset);
                  dez  <= dez_preset;
                  fsm  <= CONTA;
               end
            end
            CONTA: begin
               if (conta_en) begin
                  if (expira) begin
                     estado       <= prox_estado;
                     caso_esp_lat <= caso_esp;
                     fim          <= 1'b1;
                     carga        <= 1'b1;
                     fsm          <= CARGA;
                  end else if (unid == 4'd0) begin
                     unid <= 4'd9;
                     dez  <= dez - 2'd1;
                  end else begin
                     unid <= unid - 4'd1;
                  end
               end
            end
            default: fsm <= CARGA;
         endcase
      end
   end

endmodule

// File: tb/tb_controla_fase.sv
// tb_controla_fase: drives a preset table and randomized ticks, and checks controla_fase against an integer-time model.
module tb_controla_fase;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       caso_esp;
   logic [3:0] unid_preset;
   logic [1:0] dez_preset;
   logic [1:0] estado;
   logic       caso_esp_lat;
   logic [3:0] unid;
   logic [1:0] dez;
   logic       carga;
   logic       fim;
   logic       pausa_m;
`ifdef CONTROLA_FASE_PAUSA_EN
   logic       pausa;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Preset table indexed by {estado, caso_esp_lat}
   logic [3:0] tab_u [8];
   logic [1:0] tab_d [8];

   controla_fase dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .caso_esp(caso_esp),
`ifdef CONTROLA_FASE_PAUSA_EN
      .pausa(pausa),
`endif
      .unid_preset(unid_preset),
      .dez_preset(dez_preset),
      .estado(estado),
      .caso_esp_lat(caso_esp_lat),
      .unid(unid),
      .dez(dez),
      .carga(carga),
      .fim(fim)
   );

`ifdef CONTROLA_FASE_PAUSA_EN
   assign pausa_m = pausa;
`else
   assign pausa_m = 1'b0;
`endif

   assign unid_preset = tab_u[{estado, caso_esp_lat}];
   assign dez_preset  = tab_d[{estado, caso_esp_lat}];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining time kept as a plain integer number of ticks.
   int   m_est = 0, m_rem = 0;
   logic m_lat = 1'b0, m_load = 1'b1, m_carga = 1'b0, m_fim = 1'b0;
   int   n_est, n_rem, p;
   logic n_lat, n_load, n_carga, n_fim, avanca;

   always_comb begin
      n_est = m_est; n_rem = m_rem; n_lat = m_lat; n_load = m_load;
      n_carga = 1'b0; n_fim = 1'b0; avanca = 1'b0; p = 0;
      if (rst) begin
         n_est = 0; n_rem = 0; n_lat = 1'b0; n_load = 1'b1;
      end else if (m_load) begin
         p = int'(tab_d[m_est*2 + int'(m_lat)]) * 10 +
             ((tab_u[m_est*2 + int'(m_lat)] > 4'd9) ? 9 : int'(tab_u[m_est*2 + int'(m_lat)]));
         if (p == 0) avanca = 1'b1;
         else begin n_rem = p; n_load = 1'b0; end
      end else if (tick && !pausa_m) begin
         if (m_rem == 1) avanca = 1'b1;
         else n_rem = m_rem - 1;
      end
      if (avanca) begin
         n_est = (m_est == 3) ? 0 : m_est + 1;
         n_lat = caso_esp; n_fim = 1'b1; n_carga = 1'b1; n_load = 1'b1;
      end
   end

   always @(posedge clk) begin
      m_est <= n_est; m_rem <= n_rem; m_lat <= n_lat; m_load <= n_load;
      m_carga <= n_carga; m_fim <= n_fim;
   end

   logic [10:0] obs, exp_v;
   assign obs   = {estado, caso_esp_lat, dez, unid, carga, fim};
   assign exp_v = {2'(m_est), m_lat, 2'(m_rem / 10), 4'(m_rem % 10), m_carga, m_fim};

   task automatic tabela_spec();
      tab_d[0] = 2'd1; tab_u[0] = 4'd0;   // 00 -> 10
      tab_d[1] = 2'd1; tab_u[1] = 4'd0;
      tab_d[2] = 2'd1; tab_u[2] = 4'd5;   // 01 -> 15
      tab_d[3] = 2'd2; tab_u[3] = 4'd2;   // 01 special -> 22
      tab_d[4] = 2'd3; tab_u[4] = 4'd0;   // 10 -> 30
      tab_d[5] = 2'd0; tab_u[5] = 4'd0;   // 10 special -> 00
      tab_d[6] = 2'd0; tab_u[6] = 4'd5;   // 11 -> 05
      tab_d[7] = 2'd0; tab_u[7] = 4'd5;
   endtask

   task automatic aplica_reset();
      rst = 1'b1; tick = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      tabela_spec();
      rst = 1'b1; tick = 1'b0; caso_esp = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (obs !== 11'd0) begin
            n_err++; $display("FAIL reset_valores: dut=%h esperado=%h", obs, 11'd0);
         end
      end
      caso_esp = 1'b0;
   endtask

   task automatic test_normal();
      logic [7:0] cargas[$];
      logic [7:0] esperado [4];
      logic       fim_ant;
      esperado[0] = {2'd1, 2'd1, 4'd5};
      esperado[1] = {2'd2, 2'd3, 4'd0};
      esperado[2] = {2'd3, 2'd0, 4'd5};
      esperado[3] = {2'd0, 2'd1, 4'd0};
      tabela_spec(); caso_esp = 1'b0; fim_ant = 1'b0;
      aplica_reset();
      for (int k = 0; k < 300; k++) begin
         tick = (k % 4 == 3);
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL normal_ciclo%0d: dut=%h esperado=%h", k, obs, exp_v);
         end
         if (k == 3) begin
            n_cmp++;
            if ({dez, unid} !== 6'h09) begin
               n_err++; $display("FAIL emprestimo_10: dut=%h esperado=%h", {dez, unid}, 6'h09);
            end
         end
         if (fim_ant) cargas.push_back({estado, dez, unid});
         fim_ant = fim;
      end
      tick = 1'b0;
      n_cmp++;
      if (cargas.size() < 4) begin
         n_err++; $display("FAIL normal_fases: dut=%0d esperado=%0d", cargas.size(), 4);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cargas[i] !== esperado[i]) begin
               n_err++; $display("FAIL normal_carga%0d: dut=%h esperado=%h", i, cargas[i], esperado[i]);
            end
         end
      end
   endtask

   task automatic test_especial();
      logic fim_ant, dois, captura;
      int   n1;
      logic [7:0] carga3;
      tabela_spec(); caso_esp = 1'b1;
      fim_ant = 1'b0; dois = 1'b0; captura = 1'b0; n1 = 0; carga3 = 8'hff;
      aplica_reset();
      for (int k = 0; k < 160; k++) begin
         tick = (k % 4 == 3);
         if (tick && estado == 2'd1) n1++;
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL especial_ciclo%0d: dut=%h esperado=%h", k, obs, exp_v);
         end
         if (captura) begin carga3 = {estado, dez, unid}; captura = 1'b0; end
         if (fim && fim_ant && !dois) begin dois = 1'b1; captura = 1'b1; end
         fim_ant = fim;
      end
      tick = 1'b0; caso_esp = 1'b0;
      n_cmp++;
      if (dois !== 1'b1) begin
         n_err++; $display("FAIL especial_fim_duplo: dut=%b esperado=%b", dois, 1'b1);
      end
      n_cmp++;
      if (n1 != 22) begin
         n_err++; $display("FAIL especial_duracao22: dut=%0d esperado=%0d", n1, 22);
      end
      n_cmp++;
      if (carga3 !== {2'd3, 2'd0, 4'd5}) begin
         n_err++; $display("FAIL especial_carga3: dut=%h esperado=%h", carga3, {2'd3, 2'd0, 4'd5});
      end
   endtask

   task automatic test_reset_meio();
      logic achou;
      tabela_spec(); caso_esp = 1'b0; achou = 1'b0;
      aplica_reset();
      for (int k = 0; k < 400 && !achou; k++) begin
         tick = (k % 4 == 3);
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL reset_meio_ciclo%0d: dut=%h esperado=%h", k, obs, exp_v);
         end
         if (estado == 2'd2 && dez == 2'd1 && unid == 4'd7) achou = 1'b1;
      end
      tick = 1'b0;
      n_cmp++;
      if (!achou) begin
         n_err++; $display("FAIL reset_meio_espera: dut=%h esperado=%h", {estado, dez, unid}, {2'd2, 2'd1, 4'd7});
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs !== 11'd0) begin
         n_err++; $display("FAIL reset_meio_zero: dut=%h esperado=%h", obs, 11'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({estado, dez, unid} !== {2'd0, 2'd1, 4'd0}) begin
         n_err++; $display("FAIL reset_meio_recarga: dut=%h esperado=%h", {estado, dez, unid}, {2'd0, 2'd1, 4'd0});
      end
   endtask

   task automatic test_clamp();
      int   c, n1;
      logic forca, chegou;
      for (int i = 0; i < 8; i++) begin tab_u[i] = 4'hC; tab_d[i] = 2'd1; end
      caso_esp = 1'b0; c = 0; n1 = 0; forca = 1'b0; chegou = 1'b0;
      aplica_reset();
      for (int k = 0; k < 400 && !chegou; k++) begin
         if (forca) begin tick = 1'b1; c = 0; end
         else begin tick = (c == 3); c = (c == 3) ? 0 : c + 1; end
         forca = 1'b0;
         if (tick && estado == 2'd1) n1++;
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL clamp_ciclo%0d: dut=%h esperado=%h", k, obs, exp_v);
         end
         if (k == 0) begin
            n_cmp++;
            if ({dez, unid} !== 6'h19) begin
               n_err++; $display("FAIL clamp_19: dut=%h esperado=%h", {dez, unid}, 6'h19);
            end
         end
         if (fim) begin
            forca = 1'b1;
            n_cmp++;
            if (carga !== 1'b1) begin
               n_err++; $display("FAIL clamp_carga: dut=%b esperado=%b", carga, 1'b1);
            end
         end
         if (estado == 2'd2) chegou = 1'b1;
      end
      tick = 1'b0;
      n_cmp++;
      if (n1 != 20) begin
         n_err++; $display("FAIL clamp_tick_perdido: dut=%0d esperado=%0d", n1, 20);
      end
      tabela_spec();
   endtask

   task automatic test_aleatorio();
      int gap;
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 3) == 0) begin tab_u[i] = 4'd0; tab_d[i] = 2'd0; end
         else begin tab_u[i] = 4'($urandom_range(0, 15)); tab_d[i] = 2'($urandom_range(0, 3)); end
      end
      gap = 0;
      aplica_reset();
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) begin
            for (int i = 0; i < 8; i++) begin
               tab_u[i] = 4'($urandom_range(0, 15)); tab_d[i] = 2'($urandom_range(0, 3));
            end
         end
         if (gap == 0) begin tick = 1'b1; gap = $urandom_range(1, 4); end
         else begin tick = 1'b0; gap--; end
         caso_esp = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 299) == 0);
`ifdef CONTROLA_FASE_PAUSA_EN
         pausa = ($urandom_range(0, 5) == 0);
`endif
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL aleatorio_ciclo%0d: dut=%h esperado=%h", k, obs, exp_v);
         end
      end
      tick = 1'b0; rst = 1'b0; caso_esp = 1'b0;
`ifdef CONTROLA_FASE_PAUSA_EN
      pausa = 1'b0;
`endif
      tabela_spec();
   endtask

`ifdef CONTROLA_FASE_PAUSA_EN
   task automatic test_pausa();
      tabela_spec(); caso_esp = 1'b0; pausa = 1'b0;
      aplica_reset();
      for (int k = 0; k < 12; k++) begin
         tick = (k % 4 == 3);
         @(negedge clk);
         n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL pausa_pre%0d: dut=%h esperado=%h", k, obs, exp_v);
         end
      end
      pausa = 1'b1;
      for (int j = 0; j < 20; j++) begin
         tick = (j % 4 == 3);
         @(negedge clk);
         n_cmp++;
         if ({fim, dez, unid} !== 7'h07 || obs !== exp_v) begin
            n_err++; $display("FAIL pausa_congelado%0d: dut=%h esperado=%h", j, {fim, dez, unid}, 7'h07);
         end
      end
      pausa = 1'b0; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      n_cmp++;
      if ({dez, unid} !== 6'h06) begin
         n_err++; $display("FAIL pausa_retoma: dut=%h esperado=%h", {dez, unid}, 6'h06);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; tick = 1'b0; caso_esp = 1'b0;
`ifdef CONTROLA_FASE_PAUSA_EN
      pausa = 1'b0;
`endif
      tabela_spec();
      test_reset();
      test_normal();
      test_especial();
      test_reset_meio();
      test_clamp();
`ifdef CONTROLA_FASE_PAUSA_EN
      test_pausa();
`endif
      test_aleatorio();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
